jts16b_snd_romarb: RTL and testbench

Sound-ROM arbiter for the S16B sound board. It shares the single SDRAM sound-ROM port between the Z80 fetch path and the uPD7759 ROM fetch path. That lets the PCM chip run in stand-alone mode, reading ADPCM data directly instead of being fed by the CPU through DRQ/NMI. It sits between `jts16b_snd` (CPU ROM address/bank decode, `jt7759` rom_* pins) and the jtframe SDRAM slot.

---
 rtl/jts16b_snd_romarb.sv | 129 ++++++++++++
 tb/tb_jts16b_snd_romarb.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/jts16b_snd_romarb.sv
// Sound-ROM arbiter: shares one SDRAM slot between the Z80 and the uPD7759 ROM ports.
// Optional macro JTS16B_SNDARB_CACHE_EN keeps each requester's last byte valid across cs drops.
module jts16b_snd_romarb #(
  parameter int          PCM_AW     = 17,
  parameter logic [18:0] PCM_OFFSET = 19'h40000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_cs,
  input  logic [18:0]       cpu_addr,
  output logic [7:0]        cpu_data,
  output logic              cpu_ok,
  input  logic              pcm_cs,
  input  logic [PCM_AW-1:0] pcm_addr,
  output logic [7:0]        pcm_data,
  output logic              pcm_ok,
  output logic              rom_cs,
  output logic [18:0]       rom_addr,
  input  logic [7:0]        rom_data,
  input  logic              rom_ok,
  output logic              gnt_pcm
);

`ifdef JTS16B_SNDARB_CACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, SETTLE, WAIT} state_t;

  state_t            state, state_d;
  logic              own, last_pcm;
  logic              cpu_val, pcm_val;
  logic [18:0]       cpu_tag;
  logic [PCM_AW-1:0] pcm_tag;
  logic              cpu_hit, pcm_hit, cpu_pend, pcm_pend;
  logic              grant, grant_pcm, fill, fill_cpu, fill_pcm;
  logic [18:0]       pcm_rom_addr;

  assign cpu_hit      = cpu_val && (cpu_tag == cpu_addr);
  assign pcm_hit      = pcm_val && (pcm_tag == pcm_addr);
  assign cpu_pend     = cpu_cs && !cpu_hit;
  assign pcm_pend     = pcm_cs && !pcm_hit;
  assign pcm_rom_addr = PCM_OFFSET + 19'(pcm_addr);
  assign fill_cpu     = fill && !own;
  assign fill_pcm     = fill && own;
  assign gnt_pcm      = own && (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    state_d   = state;
    grant     = 1'b0;
    grant_pcm = 1'b0;
    fill      = 1'b0;
    case (state)
      IDLE: begin
        if (pcm_pend || cpu_pend) begin
          grant     = 1'b1;
          // PCM wins ties unless it owned the previous fetch, so neither side can starve.
          grant_pcm = pcm_pend && !(cpu_pend && last_pcm);
          state_d   = SETTLE;
        end
      end
      SETTLE: state_d = WAIT;  // rom_ok here still refers to the previous address
      WAIT: begin
        if (rom_ok) begin
          fill    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      own      <= 1'b0;
      last_pcm <= 1'b0;
      rom_cs   <= 1'b0;
      rom_addr <= '0;
      cpu_val  <= 1'b0;
      pcm_val  <= 1'b0;
      cpu_tag  <= '0;
      pcm_tag  <= '0;
      cpu_data <= '0;
      pcm_data <= '0;
      cpu_ok   <= 1'b0;
      pcm_ok   <= 1'b0;
    end else begin
      if (grant) begin
        own      <= grant_pcm;
        rom_cs   <= 1'b1;
        rom_addr <= grant_pcm ? pcm_rom_addr : cpu_addr;
        if (grant_pcm) begin
          pcm_tag <= pcm_addr;
          pcm_val <= 1'b0;
        end else begin
          cpu_tag <= cpu_addr;
          cpu_val <= 1'b0;
        end
      end
      if (fill) begin
        rom_cs   <= 1'b0;
        last_pcm <= own;
        if (own) begin
          pcm_data <= rom_data;
          pcm_val  <= 1'b1;
        end else begin
          cpu_data <= rom_data;
          cpu_val  <= 1'b1;
        end
      end
      // Without the cache a dropped cs forgets the byte; this overrides a fill on the same edge.
      if (!CACHE_EN && !cpu_cs) cpu_val <= 1'b0;
      if (!CACHE_EN && !pcm_cs) pcm_val <= 1'b0;
      // ok looks ahead through a same-edge fill so data and ok appear together.
      cpu_ok <= cpu_cs && (fill_cpu ? (cpu_tag == cpu_addr) : cpu_hit);
      pcm_ok <= pcm_cs && (fill_pcm ? (pcm_tag == pcm_addr) : pcm_hit);
    end
  end

endmodule

// File: tb/tb_jts16b_snd_romarb.sv
// Self-checking bench for jts16b_snd_romarb: directed vector table plus hand-written corner sequences.
module tb_jts16b_snd_romarb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_cs, pcm_cs;
  logic [18:0] cpu_addr;
  logic [16:0] pcm_addr;
  logic [7:0]  cpu_data, pcm_data, rom_data;
  logic        cpu_ok, pcm_ok, rom_cs, rom_ok, gnt_pcm;
  logic [18:0] rom_addr;

  int checks   = 0;
  int failures = 0;

  jts16b_snd_romarb dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cpu_cs   (cpu_cs),
    .cpu_addr (cpu_addr),
    .cpu_data (cpu_data),
    .cpu_ok   (cpu_ok),
    .pcm_cs   (pcm_cs),
    .pcm_addr (pcm_addr),
    .pcm_data (pcm_data),
    .pcm_ok   (pcm_ok),
    .rom_cs   (rom_cs),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .rom_ok   (rom_ok),
    .gnt_pcm  (gnt_pcm)
  );

  always #5 clk = ~clk;

  // SDRAM model: ok once rom_cs has been high for lat edges; ovr forces a stale ok/data.
  int cnt = 0;
  int lat = 1;
  bit ovr = 1'b0;

  function automatic logic [7:0] mdat(input logic [18:0] a);
    return a[7:0] ^ 8'h86 ^ {5'd0, a[18:16]};
  endfunction

  always @(posedge clk) begin
    if (!rom_cs)      cnt <= 0;
    else if (cnt < 15) cnt <= cnt + 1;
  end

  assign rom_ok   = ovr | (rom_cs && (cnt >= lat));
  assign rom_data = ovr ? 8'hEE : mdat(rom_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  typedef struct {
    bit          is_pcm;
    logic [18:0] addr;
    logic [18:0] exp_ra;
    logic [7:0]  exp_d;
  } vec_t;

  vec_t vecs[6];

  task automatic do_req(input vec_t v, input int idx);
    int   c;
    bit   seen, okv;
    logic [18:0] ra;
    logic        g;
    seen = 1'b0; ra = '0; g = 1'b0;
    if (v.is_pcm) begin pcm_addr = v.addr[16:0]; pcm_cs = 1'b1; end
    else          begin cpu_addr = v.addr;       cpu_cs = 1'b1; end
    for (c = 0; c < 20; c++) begin
      @(negedge clk);
      if (rom_cs && !seen) begin seen = 1'b1; ra = rom_addr; g = gnt_pcm; end
      okv = v.is_pcm ? pcm_ok : cpu_ok;
      if (okv) break;
      next_cycle();
    end
    check($sformatf("vec%0d latency", idx), c, 3);
    check($sformatf("vec%0d rom_addr", idx), ra, v.exp_ra);
    check($sformatf("vec%0d gnt_pcm", idx), g, v.is_pcm);
    check($sformatf("vec%0d data", idx), v.is_pcm ? pcm_data : cpu_data, v.exp_d);
    next_cycle();
    cpu_cs = 1'b0;
    pcm_cs = 1'b0;
    next_cycle();
    @(negedge clk);
    check($sformatf("vec%0d ok falls", idx), v.is_pcm ? pcm_ok : cpu_ok, 0);
    next_cycle();
  endtask

  bit order[4];
  int ng, cpu_lat;
  bit prev_cs, pok, cok, pok_d, cok_d;

  initial begin
    vecs[0] = '{1'b0, 19'h00123, 19'h00123, 8'hA5};
    vecs[1] = '{1'b1, 19'h00010, 19'h40010, 8'h92};
    vecs[2] = '{1'b0, 19'h7FFFF, 19'h7FFFF, 8'h7E};
    vecs[3] = '{1'b1, 19'h1FFFF, 19'h5FFFF, 8'h7C};
    vecs[4] = '{1'b1, 19'h00000, 19'h40000, 8'h82};
    vecs[5] = '{1'b0, 19'h00000, 19'h00000, 8'h86};

    rst_n = 1'b0; cpu_cs = 1'b0; pcm_cs = 1'b0; cpu_addr = '0; pcm_addr = '0;
    #3;
    check("rst cpu_ok", cpu_ok, 0);
    check("rst pcm_ok", pcm_ok, 0);
    check("rst cpu_data", cpu_data, 0);
    check("rst pcm_data", pcm_data, 0);
    check("rst rom_cs", rom_cs, 0);
    check("rst rom_addr", rom_addr, 0);
    check("rst gnt_pcm", gnt_pcm, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    next_cycle();

    for (int i = 0; i < 6; i++) do_req(vecs[i], i);

    // Simultaneous requests with PCM chasing new addresses: grants must alternate.
    pulse_reset();
    next_cycle();
    cpu_addr = 19'h00200; pcm_addr = 17'h00300; cpu_cs = 1'b1; pcm_cs = 1'b1;
    ng = 0; cpu_lat = -1; prev_cs = 1'b0; pok_d = 1'b0; cok_d = 1'b0;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      @(negedge clk);
      if (rom_cs && !prev_cs && ng < 4) begin order[ng] = gnt_pcm; ng++; end
      prev_cs = rom_cs;
      if (cpu_ok && cpu_lat < 0) cpu_lat = c;
      pok = pcm_ok && !pok_d; cok = cpu_ok && !cok_d;
      pok_d = pcm_ok; cok_d = cpu_ok;
      next_cycle();
      if (pok) pcm_addr = pcm_addr + 17'd1;
      if (cok) cpu_addr = cpu_addr + 19'd1;
    end
    check("grant count", ng, 4);
    check("grant order", {order[0], order[1], order[2], order[3]}, 4'b1010);
    check("cpu latency bound", (cpu_lat >= 0 && cpu_lat <= 6), 1);
    cpu_cs = 1'b0; pcm_cs = 1'b0;
    repeat (6) next_cycle();

    // Stale rom_ok in SETTLE must be ignored.
    ovr = 1'b1;
    cpu_addr = 19'h00455; cpu_cs = 1'b1;
    @(negedge clk); next_cycle();
    @(negedge clk);
    check("stale settle rom_cs", rom_cs, 1);
    next_cycle();
    ovr = 1'b0;
    @(negedge clk);
    check("stale not latched", cpu_ok, 0);
    next_cycle();
    @(negedge clk);
    check("stale wait ok", cpu_ok, 1);
    check("stale wait data", cpu_data, 8'hD3);
    next_cycle();
    cpu_cs = 1'b0;
    repeat (3) next_cycle();

    // Address change during WAIT: old fetch completes, ok stays low, refetch follows.
    cpu_addr = 19'h00100; cpu_cs = 1'b1;
    @(negedge clk); next_cycle();
    @(negedge clk);
    check("chg settle addr", rom_addr, 19'h00100);
    next_cycle();
    cpu_addr = 19'h00101;
    @(negedge clk); next_cycle();
    @(negedge clk);
    check("chg ok low", cpu_ok, 0);
    check("chg old data", cpu_data, 8'h86);
    check("chg idle gap", rom_cs, 0);
    next_cycle();
    @(negedge clk);
    check("chg refetch cs", rom_cs, 1);
    check("chg refetch addr", rom_addr, 19'h00101);
    next_cycle();
    @(negedge clk); next_cycle();
    @(negedge clk);
    check("chg ok", cpu_ok, 1);
    check("chg data", cpu_data, 8'h87);

    // Drop and re-raise cs at the same address.
    next_cycle();
    cpu_cs = 1'b0;
    @(negedge clk);
    check("drop ok holds", cpu_ok, 1);
    next_cycle();
    cpu_cs = 1'b1;
    @(negedge clk);
    check("drop ok falls", cpu_ok, 0);
    next_cycle();
    @(negedge clk);
`ifdef JTS16B_SNDARB_CACHE_EN
    check("cache hit ok", cpu_ok, 1);
    check("cache no fetch", rom_cs, 0);
`else
    check("nocache ok low", cpu_ok, 0);
    check("nocache fetch cs", rom_cs, 1);
    check("nocache fetch addr", rom_addr, 19'h00101);
    for (int c = 0; c < 10 && !cpu_ok; c++) begin
      next_cycle();
      @(negedge clk);
    end
    check("nocache ok", cpu_ok, 1);
    check("nocache data", cpu_data, 8'h87);
`endif

    // Async reset while a PCM fetch sits in WAIT.
    lat = 4;
    next_cycle();
    pcm_addr = 17'h00020; pcm_cs = 1'b1;
    @(negedge clk); next_cycle();
    @(negedge clk); next_cycle();
    @(negedge clk);
    check("wait rom_cs", rom_cs, 1);
    check("wait gnt_pcm", gnt_pcm, 1);
    check("wait cpu_ok", cpu_ok, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async rom_cs", rom_cs, 0);
    check("async gnt_pcm", gnt_pcm, 0);
    check("async cpu_ok", cpu_ok, 0);
    check("async pcm_ok", pcm_ok, 0);
    check("async rom_addr", rom_addr, 0);
    cpu_cs = 1'b0; pcm_cs = 1'b0; lat = 1;
    next_cycle();
    rst_n = 1'b1;
    repeat (2) next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
